// File: rtl/collision_detector_if.sv
// Per-pixel draw requests in, per-frame collision pulses and credit count out.
// Master drives the pixel/frame stimulus; slave is the detector.
interface collision_detector_if;
    logic        startOfFrame;
    logic        pause;
    logic        drawBall;
    logic        drawFlipper;
    logic        drawObstacle;
    logic        drawSpring;
    logic        drawBumper;
    logic        drawFrame;
    logic        drawCredit;
    logic [3:0]  hitEdgeCode;
    logic        collisionBallFlipper;
    logic        collisionBallObstacle;
    logic        collisionBallSpring;
    logic        collisionBallBumper;
    logic        collisionBallFrame;
    logic        collisionBallCredit;
    logic [3:0]  collisionEdge;
    logic [15:0] creditCount;

    modport master (
        output startOfFrame, pause, drawBall, drawFlipper, drawObstacle, drawSpring,
               drawBumper, drawFrame, drawCredit, hitEdgeCode,
        input  collisionBallFlipper, collisionBallObstacle, collisionBallSpring,
               collisionBallBumper, collisionBallFrame, collisionBallCredit,
               collisionEdge, creditCount
    );

    modport slave (
        input  startOfFrame, pause, drawBall, drawFlipper, drawObstacle, drawSpring,
               drawBumper, drawFrame, drawCredit, hitEdgeCode,
        output collisionBallFlipper, collisionBallObstacle, collisionBallSpring,
               collisionBallBumper, collisionBallFrame, collisionBallCredit,
               collisionEdge, creditCount
    );
endinterface

// File: rtl/collision_detector.sv
// Accumulates ball/object overlaps over a frame and reports them as one-clk
// pulses right after the frame boundary, with per-type cooldown masking.
module collision_detector #(
    parameter int          COOLDOWN_FRAMES = 3,
    parameter logic [15:0] CREDIT_MAX      = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    collision_detector_if.slave  bus
);
    localparam int NT   = 6;
    localparam int NE   = 5;   // edge-carrying types occupy the low indices
    localparam int FLIP = 0;
    localparam int OBST = 1;
    localparam int SPRG = 2;
    localparam int BUMP = 3;
    localparam int FRAM = 4;
    localparam int CRED = 5;

    localparam logic [3:0] COOLDOWN_LOAD = 4'(COOLDOWN_FRAMES);

    logic [NT-1:0] overlap;
    logic [NT-1:0] hit;
    logic [NT-1:0] fire;
    logic [NT-1:0] pulse;
    logic [3:0]    edgeAcc [NE];
    logic [3:0]    cooldown [NT];
    logic [3:0]    edgeQ;
    logic [3:0]    selEdge;
    logic [15:0]   creditQ;

    always_comb begin
        overlap = {bus.drawCredit, bus.drawFrame, bus.drawBumper,
                   bus.drawSpring, bus.drawObstacle, bus.drawFlipper} & {NT{bus.drawBall}};
    end

    // A type fires only at the frame boundary, using the hit flag as it stood
    // before this cycle; the boundary cycle's own overlap belongs to the new frame.
    always_comb begin
        fire = '0;
        for (int t = 0; t < NT; t++) begin
            fire[t] = bus.startOfFrame & ~bus.pause & hit[t] & (cooldown[t] == 4'd0);
        end
    end

    // Later assignments win: Frame > Flipper > Bumper > Spring > Obstacle.
    always_comb begin
        selEdge = edgeQ;
        if (fire[OBST]) selEdge = edgeAcc[OBST];
        if (fire[SPRG]) selEdge = edgeAcc[SPRG];
        if (fire[BUMP]) selEdge = edgeAcc[BUMP];
        if (fire[FLIP]) selEdge = edgeAcc[FLIP];
        if (fire[FRAM]) selEdge = edgeAcc[FRAM];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit     <= '0;
            pulse   <= '0;
            edgeQ   <= 4'h0;
            creditQ <= 16'h0000;
            for (int t = 0; t < NE; t++) edgeAcc[t] <= 4'h0;
            for (int t = 0; t < NT; t++) cooldown[t] <= 4'd0;
        end else begin
            pulse <= fire;
            edgeQ <= selEdge;
            if (fire[CRED] && creditQ != CREDIT_MAX) creditQ <= creditQ + 16'd1;
            for (int t = 0; t < NT; t++) begin
                if (bus.startOfFrame) hit[t] <= overlap[t];
                else                  hit[t] <= hit[t] | overlap[t];
                if (fire[t])
                    cooldown[t] <= COOLDOWN_LOAD;
                else if (bus.startOfFrame && !bus.pause && cooldown[t] != 4'd0)
                    cooldown[t] <= cooldown[t] - 4'd1;
            end
            for (int t = 0; t < NE; t++) begin
                if (bus.startOfFrame)
                    edgeAcc[t] <= overlap[t] ? bus.hitEdgeCode : 4'h0;
                else if (overlap[t])
                    edgeAcc[t] <= edgeAcc[t] | bus.hitEdgeCode;
            end
        end
    end

    assign bus.collisionBallFlipper  = pulse[FLIP];
    assign bus.collisionBallObstacle = pulse[OBST];
    assign bus.collisionBallSpring   = pulse[SPRG];
    assign bus.collisionBallBumper   = pulse[BUMP];
    assign bus.collisionBallFrame    = pulse[FRAM];
    assign bus.collisionBallCredit   = pulse[CRED];
    assign bus.collisionEdge         = edgeQ;
    assign bus.creditCount           = creditQ;
endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: default-parameter instance for the
// main behaviour, plus a CREDIT_MAX=2 instance for credit saturation.
module tb_collision_detector;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    collision_detector_if bus ();
    collision_detector_if bus2 ();

    collision_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    collision_detector #(.COOLDOWN_FRAMES(3), .CREDIT_MAX(16'd2)) dutSat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit order: {credit, frame, bumper, spring, obstacle, flipper}
    function automatic logic [5:0] pulses();
        return {bus.collisionBallCredit, bus.collisionBallFrame, bus.collisionBallBumper,
                bus.collisionBallSpring, bus.collisionBallObstacle, bus.collisionBallFlipper};
    endfunction

    task automatic clearDraws();
        bus.drawBall     = 1'b0;
        bus.drawFlipper  = 1'b0;
        bus.drawObstacle = 1'b0;
        bus.drawSpring   = 1'b0;
        bus.drawBumper   = 1'b0;
        bus.drawFrame    = 1'b0;
        bus.drawCredit   = 1'b0;
        bus.hitEdgeCode  = 4'h0;
    endtask

    task automatic setDraws(input logic [5:0] mask, input logic [3:0] code);
        bus.drawBall     = 1'b1;
        bus.drawFlipper  = mask[0];
        bus.drawObstacle = mask[1];
        bus.drawSpring   = mask[2];
        bus.drawBumper   = mask[3];
        bus.drawFrame    = mask[4];
        bus.drawCredit   = mask[5];
        bus.hitEdgeCode  = code;
    endtask

    task automatic drive(input logic [5:0] mask, input logic [3:0] code);
        setDraws(mask, code);
        @(negedge clk);
        clearDraws();
    endtask

    task automatic frameTick(input logic p);
        bus.pause        = p;
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic frameTick2();
        bus2.startOfFrame = 1'b1;
        @(negedge clk);
        bus2.startOfFrame = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        clearDraws();
        bus.startOfFrame  = 1'b0;
        bus.pause         = 1'b0;
        bus2.startOfFrame = 1'b0;
        bus2.pause        = 1'b0;
        bus2.drawBall     = 1'b0;
        bus2.drawFlipper  = 1'b0;
        bus2.drawObstacle = 1'b0;
        bus2.drawSpring   = 1'b0;
        bus2.drawBumper   = 1'b0;
        bus2.drawFrame    = 1'b0;
        bus2.drawCredit   = 1'b0;
        bus2.hitEdgeCode  = 4'h0;

        repeat (3) @(negedge clk);
        checkVal("reset_pulses", 32'(pulses()), 32'h0);
        checkVal("reset_edge", 32'(bus.collisionEdge), 32'h0);
        checkVal("reset_credit", 32'(bus.creditCount), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single flipper overlap over three pixels
        drive(6'b000001, 4'h1);
        drive(6'b000001, 4'h2);
        drive(6'b000001, 4'h2);
        repeat (2) @(negedge clk);
        frameTick(1'b0);
        checkVal("flip_pulse", 32'(pulses()), 32'h01);
        checkVal("flip_edge", 32'(bus.collisionEdge), 32'h3);
        @(negedge clk);
        checkVal("flip_one_clk", 32'(pulses()), 32'h00);

        // Bumper every frame for six frames, cooldown 3
        for (int f = 1; f <= 6; f++) begin
            drive(6'b001000, 4'h4);
            @(negedge clk);
            frameTick(1'b0);
            checkVal($sformatf("bump_frame%0d", f), 32'(pulses()),
                     (f == 1 || f == 5) ? 32'h08 : 32'h00);
            if (f == 1) checkVal("bump_edge", 32'(bus.collisionEdge), 32'h4);
        end

        // Frame and obstacle in one frame
        drive(6'b010000, 4'h8);
        drive(6'b000010, 4'h4);
        frameTick(1'b0);
        checkVal("prio_pulses", 32'(pulses()), 32'h12);
        checkVal("prio_edge", 32'(bus.collisionEdge), 32'h8);

        // Paused frame: accumulates but no pulse, cooldowns frozen
        bus.pause = 1'b1;
        drive(6'b000100, 4'h2);
        frameTick(1'b1);
        checkVal("pause_no_pulse", 32'(pulses()), 32'h00);
        bus.pause = 1'b0;
        drive(6'b000100, 4'h2);
        frameTick(1'b0);
        checkVal("spring_pulse", 32'(pulses()), 32'h04);
        checkVal("spring_edge", 32'(bus.collisionEdge), 32'h2);
        frameTick(1'b0);
        checkVal("idle_no_pulse", 32'(pulses()), 32'h00);
        checkVal("edge_hold", 32'(bus.collisionEdge), 32'h2);
        drive(6'b010000, 4'h1);
        frameTick(1'b0);
        checkVal("frame_still_cool", 32'(pulses()), 32'h00);
        drive(6'b010000, 4'h1);
        frameTick(1'b0);
        checkVal("frame_cool_done", 32'(pulses()), 32'h10);
        checkVal("frame_edge", 32'(bus.collisionEdge), 32'h1);

        // Back-to-back frame boundaries; overlap on the first boundary cycle
        bus.startOfFrame = 1'b1;
        setDraws(6'b000010, 4'h4);
        @(negedge clk);
        clearDraws();
        checkVal("b2b_first", 32'(pulses()), 32'h00);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        checkVal("b2b_second", 32'(pulses()), 32'h02);
        checkVal("b2b_edge", 32'(bus.collisionEdge), 32'h4);

        // Credit pulse carries no edge
        drive(6'b100000, 4'hF);
        frameTick(1'b0);
        checkVal("credit_pulse", 32'(pulses()), 32'h20);
        checkVal("credit_count1", 32'(bus.creditCount), 32'h1);
        checkVal("credit_edge_hold", 32'(bus.collisionEdge), 32'h4);
        repeat (3) frameTick(1'b0);

        // Reset in mid-frame discards pending credit hit
        drive(6'b100000, 4'h0);
        reset = 1'b1;
        #1;
        checkVal("async_rst_credit", 32'(bus.creditCount), 32'h0);
        checkVal("async_rst_edge", 32'(bus.collisionEdge), 32'h0);
        checkVal("async_rst_pulses", 32'(pulses()), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frameTick(1'b0);
        checkVal("post_rst_no_pulse", 32'(pulses()), 32'h00);
        checkVal("post_rst_credit", 32'(bus.creditCount), 32'h0);
        drive(6'b000001, 4'h5);
        frameTick(1'b0);
        checkVal("post_rst_flip", 32'(pulses()), 32'h01);
        checkVal("post_rst_edge", 32'(bus.collisionEdge), 32'h5);

        // Credit saturation at CREDIT_MAX=2
        for (int k = 0; k < 4; k++) begin
            bus2.drawBall   = 1'b1;
            bus2.drawCredit = 1'b1;
            @(negedge clk);
            bus2.drawBall   = 1'b0;
            bus2.drawCredit = 1'b0;
            frameTick2();
            checkVal($sformatf("sat_pulse%0d", k), 32'(bus2.collisionBallCredit), 32'h1);
            checkVal($sformatf("sat_count%0d", k), 32'(bus2.creditCount), (k == 0) ? 32'h1 : 32'h2);
            repeat (3) frameTick2();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 3: frames a collision type stays masked after being reported (1..15).
REQ-002 Parameter CREDIT_MAX, default 16'hFFFF: saturation value of creditCount.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 startOfFrame  input  1  one-clk pulse marking frame boundary.
REQ-006 pause  input  1  game paused.
REQ-007 drawBall, drawFlipper, drawObstacle, drawSpring, drawBumper, drawFrame, drawCredit  input  1 each  per-pixel draw requests for the current pixel.
REQ-008 hitEdgeCode  input  4  ball edge region of the current pixel, valid when drawBall=1.
REQ-009 collisionBallFlipper, collisionBallObstacle, collisionBallSpring, collisionBallBumper, collisionBallFrame, collisionBallCredit  output  1 each  one-clk collision pulses.
REQ-010 collisionEdge  output  4  edge code of the highest-priority reported collision.
REQ-011 creditCount  output  16  saturating count of reported credit collisions.

Function
REQ-012 Overlap for type T on a cycle SHALL be drawBall & drawT; evaluated every clk, including the startOfFrame cycle.
REQ-013 Per type, a sticky hit flag SHALL set on overlap and an edge accumulator SHALL OR in hitEdgeCode on overlap, during the current frame.
REQ-014 On startOfFrame, each type's hit flag and edge accumulator SHALL be captured into a publish register and then cleared; an overlap on the startOfFrame cycle itself SHALL count toward the new frame.
REQ-015 Collision pulses SHALL be asserted exactly on the clk after startOfFrame, for one clk, for every captured type whose cooldown counter is 0 and when pause=0.
REQ-016 Each type SHALL have a 4-bit cooldown counter; on its pulse it SHALL load COOLDOWN_FRAMES; otherwise at each startOfFrame with pause=0 it SHALL decrement if nonzero.
REQ-017 A captured hit with nonzero cooldown SHALL be discarded, not deferred.
REQ-018 Multiple types in one frame SHALL all pulse on the same clk.
REQ-019 collisionEdge SHALL update on the pulse clk to the captured edge of the highest-priority pulsing type (Frame > Flipper > Bumper > Spring > Obstacle); Credit carries no edge; if no edge-carrying type pulses it SHALL hold.
REQ-020 creditCount SHALL increment by 1 on each collisionBallCredit pulse, saturating at CREDIT_MAX.
REQ-021 pause=1: accumulation continues, captures still clear accumulators, no pulses, cooldowns frozen, creditCount frozen.
REQ-022 Two startOfFrame pulses on consecutive clks: second SHALL capture only overlaps seen on the first's cycle; pulses per REQ-015 for each.
REQ-023 Latency: overlap to pulse = remaining frame time + 1 clk; no pulse SHALL occur other than the clk after startOfFrame.

Reset
REQ-024 On reset assertion, all outputs SHALL go to 0 immediately: pulses 0, collisionEdge 4'h0, creditCount 0.
REQ-025 Reset SHALL clear hit flags, edge accumulators, publish registers and cooldown counters; a frame in progress SHALL be discarded.
REQ-026 After reset release, the first startOfFrame SHALL publish only overlaps seen after release.

Verification
REQ-027 Single overlap: drawBall=drawFlipper=1 for 3 clks with hitEdgeCode 4'h1, 4'h2, 4'h2 -> at the next startOfFrame+1, collisionBallFlipper=1 for 1 clk and collisionEdge=4'h3.
REQ-028 Cooldown with COOLDOWN_FRAMES=3: Bumper overlap every frame for 6 frames -> pulses in frames 1 and 5 only.
REQ-029 Priority: Frame (edge 4'h8) and Obstacle (edge 4'h4) in the same frame -> both pulses on one clk, collisionEdge=4'h8.
REQ-030 Pause: Spring overlap with pause=1 -> no pulse; cooldown unchanged; next frame with pause=0 and overlap -> pulse.
REQ-031 Reset mid-frame: Credit overlap, then reset asserted before startOfFrame -> outputs 0 asynchronously, no pulse at the next startOfFrame, creditCount=0.
REQ-032 Saturation: CREDIT_MAX=2, 4 credit pulses -> creditCount reads 1, 2, 2, 2.
